// File: rtl/pwm_bank_pkg.sv
// Shared constants for the Wishbone PWM bank: register offsets, bit
// positions, legal parameter limits and a byte-lane merge helper.
package pwm_bank_pkg;

  localparam int NCH_MIN = 1;
  localparam int NCH_MAX = 16;
  localparam int CW_MIN  = 8;
  localparam int CW_MAX  = 16;

  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_PERIOD = 8'h04;
  localparam logic [7:0] OFS_STATUS = 8'h08;
  localparam logic [7:0] OFS_DUTY0  = 8'h10;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_OE     = 2;
  localparam int STATUS_WRAP = 0;

  // Replace only the byte lanes selected by sel; other lanes keep old_v.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow register plus registered compare output.
module pwm_channel
  import pwm_bank_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [CW-1:0] duty_i,
  input  logic [CW-1:0] cnt_i,
  output logic          pwm_o
);

  logic [CW-1:0] duty_sh_q, duty_sh_d;
  logic          pwm_q, pwm_d;

  // Shadow follows the programmed duty only at load points; compare against it.
  always_comb begin
    duty_sh_d = load_i ? duty_i : duty_sh_q;
    pwm_d     = en_i && (cnt_i < duty_sh_q);
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      duty_sh_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/wb_pwm_bank.sv
// Wishbone-attached bank of NCH PWM channels sharing one period counter.
module wb_pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int          NCH      = 8,
  parameter int          CW       = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_cyc_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  output logic [NCH-1:0] pwm_o,
  output logic [NCH-1:0] pwm_oeb_o,
  output logic           irq_o
);

  localparam logic [5:0] W_CTRL   = OFS_CTRL[7:2];
  localparam logic [5:0] W_PERIOD = OFS_PERIOD[7:2];
  localparam logic [5:0] W_STATUS = OFS_STATUS[7:2];
  localparam logic [5:0] W_DUTY0  = OFS_DUTY0[7:2];

  logic [2:0]    ctrl_q, ctrl_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] period_sh_q, period_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] duty_q [NCH];
  logic [CW-1:0] duty_d [NCH];
  logic          wrap_pend_q, wrap_pend_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;

  logic          addressed, xfer, wr, clr, en, wrap, load_sh;
  logic [5:0]    word;
  logic [31:0]   rd_data;
  logic          unused_adr_lsb;

  // A transfer is taken once; the ack cycle masks it so a held strobe is not re-executed.
  assign addressed      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign xfer           = addressed & ~ack_q;
  assign wr             = xfer & wbs_we_i;
  assign word           = wbs_adr_i[7:2];
  assign unused_adr_lsb = ^wbs_adr_i[1:0];
  assign en             = ctrl_q[CTRL_EN];
  assign wrap           = en && (cnt_q == period_sh_q);
  assign load_sh        = ~en | wrap;

  // Read mux; unmapped words and duty slots beyond NCH read as zero.
  always_comb begin
    rd_data = '0;
    case (word)
      W_CTRL:   rd_data = 32'(ctrl_q);
      W_PERIOD: rd_data = 32'(period_q);
      W_STATUS: rd_data = 32'(wrap_pend_q);
      default:  rd_data = '0;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (word == W_DUTY0 + 6'(i)) rd_data = 32'(duty_q[i]);
    end
  end

  // Register writes with byte-lane merge; truncation drops bits above each field.
  always_comb begin
    ctrl_d   = ctrl_q;
    period_d = period_q;
    duty_d   = duty_q;
    if (wr && word == W_CTRL)
      ctrl_d = 3'(merge_bytes(32'(ctrl_q), wbs_dat_i, wbs_sel_i));
    if (wr && word == W_PERIOD)
      period_d = CW'(merge_bytes(32'(period_q), wbs_dat_i, wbs_sel_i));
    for (int i = 0; i < NCH; i++) begin
      if (wr && word == W_DUTY0 + 6'(i))
        duty_d[i] = CW'(merge_bytes(32'(duty_q[i]), wbs_dat_i, wbs_sel_i));
    end
  end

  // Counter, period shadow, wrap flag (a wrap beats a same-cycle clear) and bus response.
  always_comb begin
    clr         = wr && (word == W_STATUS) && wbs_sel_i[0] && wbs_dat_i[STATUS_WRAP];
    wrap_pend_d = wrap | (wrap_pend_q & ~clr);
    cnt_d       = (!en || wrap) ? '0 : cnt_q + CW'(1);
    period_sh_d = load_sh ? period_q : period_sh_q;
    ack_d       = xfer;
    dat_d       = (xfer & ~wbs_we_i) ? rd_data : '0;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_q      <= '0;
      period_q    <= '0;
      period_sh_q <= '0;
      cnt_q       <= '0;
      duty_q      <= '{default: '0};
      wrap_pend_q <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      period_q    <= period_d;
      period_sh_q <= period_sh_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      wrap_pend_q <= wrap_pend_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_channel #(.CW(CW)) u_ch (
      .clk_i  (wb_clk_i),
      .rst_i  (wb_rst_i),
      .load_i (load_sh),
      .en_i   (en),
      .duty_i (duty_q[g]),
      .cnt_i  (cnt_q),
      .pwm_o  (pwm_o[g])
    );
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign pwm_oeb_o = {NCH{~ctrl_q[CTRL_OE]}};
  assign irq_o     = wrap_pend_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_wb_pwm_bank.sv
// Directed bench for wb_pwm_bank: register access, PWM waveforms, wrap interrupt, reset.
module tb_wb_pwm_bank;

  localparam int          NCH  = 8;
  localparam int          CW   = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]     sel = 4'h0;
  logic [31:0]    adr = '0, wdat = '0;
  logic           ack;
  logic [31:0]    rdat;
  logic [NCH-1:0] pwm, oeb;
  logic           irq;

  int checks   = 0;
  int failures = 0;
  int ek       = 0;
  int dv       = 0;
  logic [31:0] exp_q [$];

  wb_pwm_bank #(.NCH(NCH), .CW(CW), .BASE_ADR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .pwm_o     (pwm),
    .pwm_oeb_o (oeb),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ek++;
  endtask

  task automatic bus_idle();
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wb_write(input logic [7:0] ofs, input logic [31:0] d, input logic [3:0] s);
    adr = BASE | 32'(ofs); wdat = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    tick();
    check("wr_ack", 32'(ack), 32'd1);
    bus_idle();
    tick();
    check("wr_ack_low", 32'(ack), 32'd0);
  endtask

  task automatic wb_read(input logic [7:0] ofs, input logic [31:0] expv);
    exp_q.push_back(expv);
    adr = BASE | 32'(ofs); sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    tick();
    check("rd_ack", 32'(ack), 32'd1);
    if (exp_q.size() > 0) check("rd_data", rdat, exp_q.pop_front());
    else check("rd_scoreboard_empty", 32'(exp_q.size()), 32'd1);
    bus_idle();
    tick();
    check("rd_dat_idle", rdat, 32'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_oeb", 32'(oeb), 32'hFF);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    tick();

    // Every offset reads zero after reset
    for (int o = 0; o <= 8'h4C; o += 4) wb_read(8'(o), 32'd0);
    check("oeb_idle", 32'(oeb), 32'hFF);
    check("irq_idle", 32'(irq), 32'd0);

    // Basic waveform with constant-low and constant-high channels
    wb_write(8'h04, 32'd9, 4'hF);
    wb_write(8'h10, 32'd3, 4'hF);
    wb_write(8'h14, 32'd0, 4'hF);
    wb_write(8'h18, 32'h0000_FFFF, 4'hF);
    wb_read(8'h04, 32'd9);
    wb_read(8'h18, 32'h0000_FFFF);
    wb_write(8'h00, 32'h5, 4'hF);
    ek = 1;
    check("oeb_on", 32'(oeb), 32'h00);
    repeat (20) begin
      check("pwm0_d3", 32'(pwm[0]), 32'(((ek - 1) % 10) < 3));
      check("pwm1_low", 32'(pwm[1]), 32'd0);
      check("pwm2_high", 32'(pwm[2]), 32'd1);
      tick();
    end

    // Duty change mid-period takes effect at the next wrap
    wb_write(8'h10, 32'd7, 4'hF);
    repeat (20) begin
      dv = (ek - 1 >= 30) ? 7 : 3;
      check("pwm0_dchg", 32'(pwm[0]), 32'(((ek - 1) % 10) < dv));
      tick();
    end

    // Disable forces outputs low on the following cycle
    wb_write(8'h00, 32'h0, 4'hF);
    check("dis_pwm", 32'(pwm), 32'd0);
    check("dis_oeb", 32'(oeb), 32'hFF);

    // Wrap interrupt with clear racing a wrap
    wb_write(8'h04, 32'd4, 4'hF);
    wb_write(8'h08, 32'd1, 4'hF);
    wb_read(8'h08, 32'd0);
    wb_write(8'h00, 32'h3, 4'hF);
    ek = 1;
    check("irq_e1", 32'(irq), 32'd0);
    repeat (3) tick();
    check("irq_e4", 32'(irq), 32'd0);
    tick();
    check("irq_e5", 32'(irq), 32'd1);
    repeat (4) tick();
    wb_write(8'h08, 32'd1, 4'hF);
    check("irq_w1c_at_wrap", 32'(irq), 32'd1);
    wb_write(8'h08, 32'd1, 4'hF);
    check("irq_w1c", 32'(irq), 32'd0);
    wb_read(8'h08, 32'd0);

    // Byte lanes, field widths, unmapped offsets, window decode
    wb_write(8'h00, 32'h0, 4'hF);
    wb_write(8'h04, 32'h0000_ABCD, 4'b0001);
    wb_read(8'h04, 32'h0000_00CD);
    wb_read(8'h40, 32'd0);
    wb_write(8'h30, 32'h1234, 4'hF);
    wb_read(8'h30, 32'd0);
    wb_write(8'h1C, 32'hFFFF_1234, 4'hF);
    wb_read(8'h1C, 32'h0000_1234);
    adr = BASE + 32'h100; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    repeat (3) begin
      tick();
      check("out_of_window_ack", 32'(ack), 32'd0);
    end
    bus_idle();
    tick();
    wb_write(8'h00, 32'hFFFF_FFFF, 4'hF);
    wb_read(8'h00, 32'h7);

    // Reset during a transfer aborts it
    adr = BASE; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    rst = 1'b1;
    tick();
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_dat", rdat, 32'd0);
    check("mid_rst_pwm", 32'(pwm), 32'd0);
    check("mid_rst_oeb", 32'(oeb), 32'hFF);
    check("mid_rst_irq", 32'(irq), 32'd0);
    bus_idle();
    rst = 1'b0;
    tick();
    wb_read(8'h00, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_pwm_bank.md
WB_PWM_BANK -- requirements
Module: wb_pwm_bank

Interface
REQ-001 SHALL have parameter NCH, default 8, meaning number of PWM channels (legal 1..16).
REQ-002 SHALL have parameter CW, default 16, meaning counter, period and duty width (legal 8..16).
REQ-003 SHALL have parameter BASE_ADR, default 32'h3000_0000, meaning 256-byte register window base, aligned to 256 bytes.
REQ-004 SHALL have port wb_clk_i, input, 1, the single clock.
REQ-005 SHALL have port wb_rst_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports wbs_stb_i, wbs_cyc_i and wbs_we_i, each input, 1, Wishbone strobe, cycle and write-enable.
REQ-007 SHALL have ports wbs_sel_i input 4, wbs_adr_i input 32 and wbs_dat_i input 32, Wishbone byte lanes, address and write data.
REQ-008 SHALL have ports wbs_ack_o output 1 and wbs_dat_o output 32, Wishbone acknowledge and read data.
REQ-009 SHALL have port pwm_o, output, NCH, PWM waveforms.
REQ-010 SHALL have port pwm_oeb_o, output, NCH, pad output-enable, active low.
REQ-011 SHALL have port irq_o, output, 1, level interrupt.

Function
REQ-012 Register map, byte offsets: CTRL 0x00 (bit0 EN, bit1 IRQ_EN, bit2 OE); PERIOD 0x04; STATUS 0x08 (bit0 WRAP_PEND, write 1 to clear); DUTY[i] at 0x10+4*i.
REQ-013 A transfer is addressed when stb&cyc are high and adr[31:8]==BASE_ADR[31:8]; only addressed transfers are acknowledged.
REQ-014 wbs_ack_o SHALL pulse high exactly one cycle, in the cycle after an addressed transfer is first seen, then stay low for at least one cycle.
REQ-015 Writes SHALL honour wbs_sel_i per byte lane; bits above CW (PERIOD, DUTY) and unused CTRL/STATUS bits SHALL be ignored on write and read 0.
REQ-016 Reads of unmapped offsets and DUTY[i] with i>=NCH SHALL be acknowledged and return 0; writes to them have no effect.
REQ-017 wbs_dat_o SHALL be valid in the ack cycle and 0 in all other cycles.
REQ-018 With EN=1, counter cnt SHALL step 0,1,...,PERIOD_SH, then wrap to 0; period is PERIOD_SH+1 cycles; PERIOD_SH=0 holds cnt at 0.
REQ-019 Shadow registers PERIOD_SH and DUTY_SH[i] SHALL load from PERIOD/DUTY[i] in the wrap cycle, and continuously while EN=0.
REQ-020 pwm_o[i] SHALL be registered, equal to EN && (cnt < DUTY_SH[i]) one cycle late; DUTY=0 gives constant low, DUTY>PERIOD gives constant high.
REQ-021 Clearing EN SHALL force cnt to 0 and all pwm_o low on the next cycle; setting EN SHALL start counting from 0.
REQ-022 pwm_oeb_o SHALL be all ~OE.
REQ-023 WRAP_PEND SHALL set in the cycle after cnt==PERIOD_SH with EN=1; irq_o = WRAP_PEND & IRQ_EN.
REQ-024 A simultaneous W1C of WRAP_PEND and a wrap event SHALL leave WRAP_PEND set.

Reset
REQ-025 On wb_rst_i high, all registers, shadows and cnt SHALL clear asynchronously to 0.
REQ-026 While in reset: wbs_ack_o=0, wbs_dat_o=0, pwm_o=0, pwm_oeb_o all 1, irq_o=0.
REQ-027 A reset asserted mid-transfer SHALL abort it without an ack; the master retries.

Structure
REQ-028 Package pwm_bank_pkg SHALL hold register offsets, CTRL/STATUS bit positions and the NCH/CW limits.
REQ-029 One sub-module, pwm_channel, SHALL hold a single channel's duty shadow and output compare register; NCH instances are generated.

Verification
REQ-030 Reset, then read every offset: all return 0; pwm_oeb_o=all 1; irq_o=0.
REQ-031 PERIOD=9, DUTY[0]=3, CTRL=0x5: pwm_o[0] repeats 3 high, 7 low, period 10 cycles.
REQ-032 While running, write DUTY[0]=7 mid-period: the current period keeps 3 high; the next period has 7 high.
REQ-033 DUTY[1]=0 and DUTY[2]=0xFFFF with PERIOD=9: pwm_o[1] constantly low and pwm_o[2] constantly high while EN=1.
REQ-034 CTRL=0x3, PERIOD=4: irq_o rises 6 cycles after enable; a STATUS=1 write in the wrap cycle leaves irq_o high; a later STATUS=1 write drops it.
REQ-035 Write with sel=4'b0001 of 0xABCD to PERIOD: reads 0x00CD; read of 0x40 acks with 0; an address outside the window gets no ack.
